// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID buffer, credit-limited request issue and wrong-path squashing.
// Optional static branch prediction is enabled with the IF_STATIC_PRED_EN macro.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic        id_pred_taken
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SW = CW + 1;
  localparam int unsigned KW = 16;
  localparam logic [SW-1:0] DEPTH_C = SW'(FIFO_DEPTH);

  logic [31:0]   pc;
  logic [31:0]   buf_instr [FIFO_DEPTH];
  logic [31:0]   buf_pc    [FIFO_DEPTH];
  logic          buf_pred  [FIFO_DEPTH];
  logic [AW-1:0] buf_rd, buf_wr;
  logic [CW-1:0] buf_cnt;

  // PCs of live (not yet squashed) requests, oldest first
  logic [31:0]   ifq_pc [FIFO_DEPTH];
  logic [AW-1:0] ifq_rd, ifq_wr;
  logic [CW-1:0] outstanding;
  logic [KW-1:0] kill_cnt;

  logic        credit, issue, pop, push, rsp_live, rsp_kill;
  logic [31:0] rsp_pc;
  logic        pred_taken;
  logic [31:0] pred_target;

  assign credit   = ({1'b0, outstanding} + {1'b0, buf_cnt}) < DEPTH_C;
  assign rsp_kill = imem_rvalid & (kill_cnt != '0);
  // outstanding==0 filters responses to requests that a reset discarded
  assign rsp_live = imem_rvalid & (kill_cnt == '0) & (outstanding != '0);
  assign rsp_pc   = ifq_pc[ifq_rd];

`ifdef IF_STATIC_PRED_EN
  logic [6:0]  opcode;
  logic        is_jal, is_bneg;
  logic [31:0] imm_j, imm_b;

  assign opcode  = imem_rdata[6:0];
  assign is_jal  = (opcode == 7'b1101111);
  assign is_bneg = (opcode == 7'b1100011) & imem_rdata[31];
  assign imm_j   = {{12{imem_rdata[31]}}, imem_rdata[19:12], imem_rdata[20],
                    imem_rdata[30:21], 1'b0};
  assign imm_b   = {{20{imem_rdata[31]}}, imem_rdata[7], imem_rdata[30:25],
                    imem_rdata[11:8], 1'b0};
  assign pred_taken  = rsp_live & (is_jal | is_bneg);
  assign pred_target = (rsp_pc + (is_jal ? imm_j : imm_b)) & ~32'h3;
`else
  assign pred_taken  = 1'b0;
  assign pred_target = 32'h0;
`endif

  assign imem_req      = !rst & !redirect_valid & !pred_taken & credit;
  assign imem_addr     = pc;
  assign issue         = imem_req & imem_ready;
  assign push          = rsp_live & !redirect_valid;
  assign id_valid      = !rst & (buf_cnt != '0);
  assign id_instr      = buf_instr[buf_rd];
  assign id_pc         = buf_pc[buf_rd];
  assign id_pred_taken = id_valid & buf_pred[buf_rd];
  assign pop           = id_valid & id_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC & ~32'h3;
      buf_rd      <= '0;
      buf_wr      <= '0;
      buf_cnt     <= '0;
      ifq_rd      <= '0;
      ifq_wr      <= '0;
      outstanding <= '0;
      kill_cnt    <= '0;
    end else if (redirect_valid) begin
      // every live request still in flight becomes a response to squash
      pc          <= redirect_pc & ~32'h3;
      buf_rd      <= '0;
      buf_wr      <= '0;
      buf_cnt     <= '0;
      ifq_rd      <= '0;
      ifq_wr      <= '0;
      outstanding <= '0;
      kill_cnt    <= kill_cnt + KW'(outstanding) - KW'(rsp_live | rsp_kill);
    end else begin
      if (pred_taken)
        pc <= pred_target;
      else if (issue)
        pc <= pc + 32'd4;

      if (issue)    ifq_wr <= ifq_wr + AW'(1);
      if (rsp_live) ifq_rd <= ifq_rd + AW'(1);

      if (pred_taken) begin
        outstanding <= '0;
        kill_cnt    <= KW'(outstanding) - KW'(1);
        ifq_rd      <= '0;
        ifq_wr      <= '0;
      end else begin
        outstanding <= outstanding + CW'(issue) - CW'(rsp_live);
        if (rsp_kill) kill_cnt <= kill_cnt - KW'(1);
      end

      if (push) buf_wr <= buf_wr + AW'(1);
      if (pop)  buf_rd <= buf_rd + AW'(1);
      buf_cnt <= buf_cnt + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      buf_instr[buf_wr] <= imem_rdata;
      buf_pc[buf_wr]    <= rsp_pc;
      buf_pred[buf_wr]  <= pred_taken;
    end
    if (issue) ifq_pc[ifq_wr] <= pc;
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: memory model, issue-time scoreboard and redirect vector table.
// Expectations for the prediction case follow the IF_STATIC_PRED_EN macro of the build.
module tb_fetch_stage;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        id_pred_taken;

  fetch_stage #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr),
    .id_pc(id_pc), .id_pred_taken(id_pred_taken)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] instr; logic [31:0] pc; } exp_t;
  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct { logic [31:0] rpc; int lat; logic [31:0] pc0; logic [31:0] pc1; } vec_t;

  exp_t        exp_q[$];
  mreq_t       mq[$];
  logic [31:0] pop_log[$];
  logic        pred_log[$];
  logic [31:0] issue_log[$];
  int  lat = 1;
  int  cyc = 0;
  int  live = 0;
  bit  special_en = 0;
  bit  sb_en = 1;
  bit  rdy_rand = 0;
  bit  idr_rand = 0;
  logic id_ready_hold = 1'b1;
  int  n_vec = 0;
  int  n_err = 0;

`ifdef IF_STATIC_PRED_EN
  localparam logic PRED_EXP = 1'b1;
  localparam logic [31:0] BEQ_NEXT = 32'h10;
  localparam logic [31:0] JAL_NEXT = 32'h48;
`else
  localparam logic PRED_EXP = 1'b0;
  localparam logic [31:0] BEQ_NEXT = 32'h24;
  localparam logic [31:0] JAL_NEXT = 32'h44;
`endif

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (special_en && a == 32'h20) return 32'hFE00_08E3; // beq x0,x0,-16
    if (special_en && a == 32'h40) return 32'h0080_006F; // jal x0,+8
    return {a[26:2], 7'h13};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // memory responder and ready generators
  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    imem_ready  = 1'b1;
    id_ready    = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      if (mq.size() > 0 && mq[0].due <= cyc) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(mq[0].addr);
        void'(mq.pop_front());
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
      end
      if (rst) mq.delete();
      imem_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      id_ready   = idr_rand ? 1'($urandom_range(0, 1)) : id_ready_hold;
    end
  end

  // monitor: compare pops, then record this cycle's issue
  exp_t e;
  always @(negedge clk) begin
    if (!rst) begin
      if (id_valid && id_ready) begin
        pop_log.push_back(id_pc);
        pred_log.push_back(id_pred_taken);
        live--;
        if (sb_en) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL sb_empty: got pop of %h, expected no instruction", id_pc);
          end else begin
            e = exp_q.pop_front();
            check("sb_pc", id_pc, e.pc);
            check("sb_instr", id_instr, e.instr);
            check("sb_pred", 32'(id_pred_taken), 32'h0);
          end
        end
      end
      if (redirect_valid) begin
        exp_q.delete();
        live = 0;
      end else if (imem_req && imem_ready) begin
        check("addr_align", 32'(imem_addr[1:0]), 32'h0);
        exp_q.push_back('{instr: mem_word(imem_addr), pc: imem_addr});
        mq.push_back('{addr: imem_addr, due: cyc + lat});
        issue_log.push_back(imem_addr);
        live++;
      end
    end
  end

  task automatic do_redirect(input logic [31:0] target);
    @(posedge clk);
    #1;
    redirect_valid = 1'b1;
    redirect_pc    = target;
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    pop_log.delete();
    pred_log.delete();
    issue_log.delete();
  endtask

  task automatic wait_pops(input int n, input int budget);
    int k = 0;
    while (pop_log.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    #1;
    if (pop_log.size() < n) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_pops: got %0d pops, expected %0d within %0d cycles", pop_log.size(), n, budget);
    end
  endtask

  task automatic check_pops(input string name, input logic [31:0] p0, input logic [31:0] p1);
    if (pop_log.size() >= 2) begin
      check({name, "_pc0"}, pop_log[0], p0);
      check({name, "_pc1"}, pop_log[1], p1);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  vec_t vecs[5];

  initial begin
    vecs[0] = '{rpc: 32'h0000_0100, lat: 3, pc0: 32'h0000_0100, pc1: 32'h0000_0104};
    vecs[1] = '{rpc: 32'h0000_0103, lat: 1, pc0: 32'h0000_0100, pc1: 32'h0000_0104};
    vecs[2] = '{rpc: 32'hFFFF_FFFC, lat: 1, pc0: 32'hFFFF_FFFC, pc1: 32'h0000_0000};
    vecs[3] = '{rpc: 32'h0000_02F0, lat: 2, pc0: 32'h0000_02F0, pc1: 32'h0000_02F4};
    vecs[4] = '{rpc: 32'h0000_0055, lat: 2, pc0: 32'h0000_0054, pc1: 32'h0000_0058};

    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_imem_req", 32'(imem_req), 32'h0);
    check("rst_id_valid", 32'(id_valid), 32'h0);
    check("rst_pred", 32'(id_pred_taken), 32'h0);

    // T1: sequential fetch, one instruction per cycle after warmup
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("first_req", 32'(imem_req), 32'h1);
    check("first_addr", imem_addr, 32'h0);
    @(posedge clk);
    @(posedge clk);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("t1_thru", 32'(id_valid), 32'h1);
    end
    check_pops("t1", 32'h0, 32'h4);

    // T2: decode stall; credit limit and stable head
    @(posedge clk);
    #1 id_ready_hold = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t2_credit", 32'(live <= DEPTH), 32'h1);
      if (exp_q.size() > 0) begin
        check("t2_hold_pc", id_pc, exp_q[0].pc);
        check("t2_hold_instr", id_instr, exp_q[0].instr);
      end
    end
    check("t2_req_drop", 32'(imem_req), 32'h0);
    check("t2_valid", 32'(id_valid), 32'h1);
    @(posedge clk);
    #1 id_ready_hold = 1'b1;
    repeat (10) @(posedge clk);

    // T3/T5: redirect table
    for (int v = 0; v < 5; v++) begin
      lat = vecs[v].lat;
      repeat (8) @(posedge clk);
      do_redirect(vecs[v].rpc);
      @(negedge clk);
      check("rd_idv0", 32'(id_valid), 32'h0);
      check("rd_req", 32'(imem_req), 32'h1);
      check("rd_addr", imem_addr, vecs[v].pc0);
      wait_pops(2, 40);
      check_pops("rd", vecs[v].pc0, vecs[v].pc1);
      if (issue_log.size() >= 2) check("rd_issue1", issue_log[1], vecs[v].pc1);
    end

    // T4: redirect coinciding with a pop and a response
    lat = 1;
    repeat (8) @(posedge clk);
    @(posedge clk);
    #1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h300;
    @(negedge clk);
    check("t4_setup_idv", 32'(id_valid & id_ready), 32'h1);
    check("t4_setup_rv", 32'(imem_rvalid), 32'h1);
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    pop_log.delete();
    pred_log.delete();
    issue_log.delete();
    wait_pops(2, 40);
    check_pops("t4", 32'h300, 32'h304);

    // random handshakes with a redirect in the middle
    lat = 2;
    rdy_rand = 1;
    idr_rand = 1;
    repeat (40) @(posedge clk);
    do_redirect(32'h400);
    repeat (40) @(posedge clk);
    rdy_rand = 0;
    idr_rand = 0;
    repeat (10) @(posedge clk);

    // T6: static prediction (or its absence)
    lat = 1;
    sb_en = 0;
    special_en = 1;
    do_redirect(32'h20);
    wait_pops(2, 40);
    check_pops("t6_beq", 32'h20, BEQ_NEXT);
    if (pred_log.size() >= 2) begin
      check("t6_beq_pred", 32'(pred_log[0]), 32'(PRED_EXP));
      check("t6_beq_pred1", 32'(pred_log[1]), 32'h0);
    end
    do_redirect(32'h40);
    wait_pops(2, 40);
    check_pops("t6_jal", 32'h40, JAL_NEXT);
    if (pred_log.size() >= 1) check("t6_jal_pred", 32'(pred_log[0]), 32'(PRED_EXP));
    do_redirect(32'h500);
    special_en = 0;
    sb_en = 1;
    repeat (15) @(posedge clk);

    // reset in mid-operation
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    live = 0;
    @(negedge clk);
    check("mrst_req", 32'(imem_req), 32'h0);
    check("mrst_idv", 32'(id_valid), 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    pop_log.delete();
    @(negedge clk);
    check("mrst_addr", imem_addr, 32'h0);
    wait_pops(2, 40);
    check_pops("mrst", 32'h0, 32'h4);
    repeat (10) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
